// File: rtl/rx_link_pkg.sv
// Shared definitions for the linkin receive deframer: lane-8 control codes,
// link state encoding and small code-classification helpers.
package rx_link_pkg;

  localparam logic [3:0] CODE_IDLE = 4'b0001;
  localparam logic [3:0] CODE_SOF  = 4'b1010;
  localparam logic [3:0] CODE_DATA = 4'b1100;
  localparam logic [3:0] CODE_EOF  = 4'b0101;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LINKED   = 2'd1,
    ST_IN_FRAME = 2'd2
  } link_state_e;

  // Training pattern: every one of the nine lanes carries the IDLE nibble.
  function automatic logic is_training(input logic [35:0] word);
    return (word == {9{CODE_IDLE}});
  endfunction

  function automatic logic is_valid_code(input logic [3:0] code);
    logic ok;
    case (code)
      CODE_IDLE, CODE_SOF, CODE_DATA, CODE_EOF: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rx_link_deframer.sv
// Link bring-up and frame extraction for aligned linkin data: waits for a
// sustained training pattern, then emits SOF/DATA/EOF framed words one cycle later.
module rx_link_deframer
  import rx_link_pkg::*;
#(
  parameter int LOCK_CNT  = 64,
  parameter int ERR_LIMIT = 8,
  parameter int MAX_WORDS = 1024
) (
  input  logic        rxoutclock,
  input  logic        reset,
  input  logic [35:0] rxout,
  input  logic        rx_locked,
  input  logic        align_active,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        dout_sof,
  output logic        dout_eof,
  output logic        frame_abort,
  output logic        link_up,
  output logic [15:0] err_count
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CNT - 1);
  localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(MAX_WORDS - 1);

  link_state_e   state_r, state_s;
  logic [LW-1:0] lock_cnt_r, lock_cnt_s;
  logic [EW-1:0] err_run_r, err_run_s;
  logic [CW-1:0] word_cnt_r, word_cnt_s;
  logic [15:0]   err_count_s;
  logic [3:0]    ctrl_s;
  logic          emit_s, sof_s, eof_s, abort_s, err_inc_s;

  assign ctrl_s = rxout[35:32];

  // Next-state, counter and output-flag decode for the current rxout sample.
  always_comb begin
    state_s    = state_r;
    lock_cnt_s = lock_cnt_r;
    err_run_s  = err_run_r;
    word_cnt_s = word_cnt_r;
    emit_s     = 1'b0;
    sof_s      = 1'b0;
    eof_s      = 1'b0;
    abort_s    = 1'b0;
    err_inc_s  = 1'b0;
    if (!rx_locked || align_active) begin
      state_s    = ST_UNLOCKED;
      lock_cnt_s = '0;
      err_run_s  = '0;
      word_cnt_s = '0;
      abort_s    = (state_r == ST_IN_FRAME);
    end else if (state_r == ST_UNLOCKED) begin
      if (is_training(rxout)) begin
        if (lock_cnt_r == LOCK_LAST) begin
          state_s    = ST_LINKED;
          lock_cnt_s = '0;
        end else begin
          lock_cnt_s = lock_cnt_r + 1'b1;
        end
      end else begin
        lock_cnt_s = '0;
      end
    end else if (!is_valid_code(ctrl_s)) begin
      err_inc_s  = 1'b1;
      word_cnt_s = '0;
      abort_s    = (state_r == ST_IN_FRAME);
      if (err_run_r == ERR_LAST) begin
        state_s   = ST_UNLOCKED;
        err_run_s = '0;
      end else begin
        state_s   = ST_LINKED;
        err_run_s = err_run_r + 1'b1;
      end
    end else begin
      err_run_s = '0;
      if (state_r == ST_LINKED) begin
        case (ctrl_s)
          CODE_SOF: begin
            state_s    = ST_IN_FRAME;
            emit_s     = 1'b1;
            sof_s      = 1'b1;
            word_cnt_s = CW'(1);
          end
          CODE_IDLE: state_s = ST_LINKED;
          // DATA/EOF with no open frame are protocol errors, not code errors.
          default:   err_inc_s = 1'b1;
        endcase
      end else begin
        case (ctrl_s)
          CODE_DATA: begin
            // A DATA word must leave room for the closing EOF word.
            if (word_cnt_r < WORD_LAST) begin
              emit_s     = 1'b1;
              word_cnt_s = word_cnt_r + 1'b1;
            end else begin
              abort_s    = 1'b1;
              state_s    = ST_LINKED;
              word_cnt_s = '0;
            end
          end
          CODE_EOF: begin
            emit_s     = 1'b1;
            eof_s      = 1'b1;
            state_s    = ST_LINKED;
            word_cnt_s = '0;
          end
          CODE_SOF: begin
            abort_s    = 1'b1;
            emit_s     = 1'b1;
            sof_s      = 1'b1;
            word_cnt_s = CW'(1);
          end
          default: begin
            abort_s    = 1'b1;
            state_s    = ST_LINKED;
            word_cnt_s = '0;
          end
        endcase
      end
    end
    if (err_inc_s && (err_count != 16'hFFFF)) begin
      err_count_s = err_count + 16'd1;
    end else begin
      err_count_s = err_count;
    end
  end

  // State and tracking counters.
  always_ff @(posedge rxoutclock) begin
    if (reset) begin
      state_r    <= ST_UNLOCKED;
      lock_cnt_r <= '0;
      err_run_r  <= '0;
      word_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      lock_cnt_r <= lock_cnt_s;
      err_run_r  <= err_run_s;
      word_cnt_r <= word_cnt_s;
    end
  end

  // Registered outputs, one cycle behind the sampled rxout.
  always_ff @(posedge rxoutclock) begin
    if (reset) begin
      dout        <= 32'h0;
      dout_valid  <= 1'b0;
      dout_sof    <= 1'b0;
      dout_eof    <= 1'b0;
      frame_abort <= 1'b0;
      link_up     <= 1'b0;
      err_count   <= 16'h0;
    end else begin
      dout        <= emit_s ? rxout[31:0] : 32'h0;
      dout_valid  <= emit_s;
      dout_sof    <= sof_s;
      dout_eof    <= eof_s;
      frame_abort <= abort_s;
      link_up     <= (state_s != ST_UNLOCKED);
      err_count   <= err_count_s;
    end
  end

endmodule

// File: tb/tb_rx_link_deframer.sv
// Directed plus randomized bench for rx_link_deframer against a behavioural
// link/frame model kept in plain integers and flags.
module tb_rx_link_deframer;
  localparam int LOCK_CNT  = 64;
  localparam int ERR_LIMIT = 8;
  localparam int MAX_WORDS = 8;
  localparam logic [35:0] TRAIN = {9{4'b0001}};
  localparam logic [3:0] C_IDLE = 4'b0001;
  localparam logic [3:0] C_SOF  = 4'b1010;
  localparam logic [3:0] C_DATA = 4'b1100;
  localparam logic [3:0] C_EOF  = 4'b0101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [35:0] rxout = 36'h0;
  logic        rx_locked = 1'b0;
  logic        align_active = 1'b0;
  logic [31:0] dout;
  logic        dout_valid, dout_sof, dout_eof, frame_abort, link_up;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  rx_link_deframer #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .MAX_WORDS(MAX_WORDS)) dut (
    .rxoutclock(clk), .reset(reset), .rxout(rxout), .rx_locked(rx_locked),
    .align_active(align_active), .dout(dout), .dout_valid(dout_valid),
    .dout_sof(dout_sof), .dout_eof(dout_eof), .frame_abort(frame_abort),
    .link_up(link_up), .err_count(err_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid_seen = 0;
  int n_abort_seen = 0;

  // reference model
  bit m_linked, m_open;
  int m_train, m_run, m_words, m_errs;
  bit e_valid, e_sof, e_eof, e_abort;
  logic [31:0] e_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] w(input logic [3:0] code, input logic [31:0] data);
    return {code, data};
  endfunction

  task automatic bump_err();
    if (m_errs < 65535) m_errs++;
  endtask

  task automatic emit(input logic [31:0] data, input bit s, input bit e);
    e_valid = 1'b1; e_sof = s; e_eof = e; e_dout = data;
  endtask

  task automatic model_step(input logic [35:0] d, input bit lk, input bit al, input bit rs);
    logic [3:0] code;
    bit known;
    code = d[35:32];
    known = (code == C_IDLE) || (code == C_SOF) || (code == C_DATA) || (code == C_EOF);
    e_valid = 0; e_sof = 0; e_eof = 0; e_abort = 0; e_dout = 32'h0;
    if (rs) begin
      m_linked = 0; m_open = 0; m_train = 0; m_run = 0; m_words = 0; m_errs = 0;
    end else if (!lk || al) begin
      e_abort = m_open;
      m_linked = 0; m_open = 0; m_train = 0; m_run = 0;
    end else if (!m_linked) begin
      m_train = (d == TRAIN) ? m_train + 1 : 0;
      if (m_train == LOCK_CNT) begin m_linked = 1; m_train = 0; m_run = 0; end
    end else if (!known) begin
      bump_err();
      m_run++;
      e_abort = m_open;
      m_open = 0;
      if (m_run == ERR_LIMIT) begin m_linked = 0; m_run = 0; end
    end else begin
      m_run = 0;
      if (!m_open) begin
        if (code == C_SOF) begin emit(d[31:0], 1, 0); m_open = 1; m_words = 1; end
        else if (code != C_IDLE) bump_err();
      end else if (code == C_DATA) begin
        // this word plus a closing EOF must still fit in the frame budget
        if (m_words + 2 <= MAX_WORDS) begin emit(d[31:0], 0, 0); m_words++; end
        else begin e_abort = 1; m_open = 0; end
      end else if (code == C_EOF) begin
        emit(d[31:0], 0, 1); m_open = 0;
      end else if (code == C_SOF) begin
        e_abort = 1; emit(d[31:0], 1, 0); m_words = 1;
      end else begin
        e_abort = 1; m_open = 0;
      end
    end
  endtask

  task automatic cycle(input logic [35:0] d, input bit lk = 1'b1, input bit al = 1'b0, input bit rs = 1'b0);
    rxout = d; rx_locked = lk; align_active = al; reset = rs;
    @(posedge clk);
    model_step(d, lk, al, rs);
    #1;
    check("dout_valid", 32'(dout_valid), 32'(e_valid));
    check("dout_sof", 32'(dout_sof), 32'(e_sof));
    check("dout_eof", 32'(dout_eof), 32'(e_eof));
    check("frame_abort", 32'(frame_abort), 32'(e_abort));
    check("link_up", 32'(link_up), 32'(m_linked));
    check("err_count", 32'(err_count), 32'(m_errs));
    if (e_valid) check("dout", dout, e_dout);
    if (dout_valid) n_valid_seen++;
    if (frame_abort) n_abort_seen++;
  endtask

  task automatic train(input int n);
    for (int i = 0; i < n; i++) cycle(TRAIN);
  endtask

  initial begin
    logic [35:0] bad;
    int r, c;
    // reset
    cycle(36'h0, 1, 0, 1);
    cycle(36'h0, 1, 0, 1);
    check("reset_dout", dout, 32'h0);
    check("reset_err", 32'(err_count), 32'h0);

    // training interrupted by one bad nibble on lane 3
    train(LOCK_CNT - 1);
    bad = TRAIN;
    bad[15:12] = 4'b0000;
    cycle(bad);
    check("no_link_after_short_run", 32'(link_up), 32'h0);
    train(LOCK_CNT - 1);
    check("no_link_before_last", 32'(link_up), 32'h0);
    train(1);
    check("link_after_full_run", 32'(link_up), 32'h1);

    // basic frame SOF, DATA x3, EOF
    n_valid_seen = 0;
    cycle(w(C_IDLE, 32'h0));
    cycle(w(C_SOF, 32'h0));
    for (int i = 1; i <= 3; i++) cycle(w(C_DATA, 32'(i)));
    cycle(w(C_EOF, 32'h4));
    cycle(w(C_IDLE, 32'h0));
    check("frame5_valids", 32'(n_valid_seen), 32'd5);

    // SOF, DATA, IDLE -> abort, still linked
    n_valid_seen = 0; n_abort_seen = 0;
    cycle(w(C_SOF, 32'hA0));
    cycle(w(C_DATA, 32'hA1));
    cycle(w(C_IDLE, 32'h0));
    check("idle_abort_valids", 32'(n_valid_seen), 32'd2);
    check("idle_abort_pulse", 32'(n_abort_seen), 32'd1);
    check("idle_abort_link", 32'(link_up), 32'h1);

    // eight consecutive code errors drop the link
    n_valid_seen = 0;
    for (int i = 0; i < ERR_LIMIT; i++) cycle(w(4'b1111, $urandom()));
    check("err8_count", 32'(err_count), 32'd8);
    check("err8_link", 32'(link_up), 32'h0);
    check("err8_no_valid", 32'(n_valid_seen), 32'd0);

    // overflow: SOF + DATA x(MAX-1) -> MAX-1 words, abort on last DATA
    train(LOCK_CNT);
    n_valid_seen = 0; n_abort_seen = 0;
    cycle(w(C_SOF, $urandom()));
    for (int i = 0; i < MAX_WORDS - 1; i++) cycle(w(C_DATA, $urandom()));
    check("ovf_valids", 32'(n_valid_seen), 32'(MAX_WORDS - 1));
    check("ovf_abort", 32'(n_abort_seen), 32'd1);

    // longest legal frame: SOF + DATA x(MAX-2) + EOF
    n_valid_seen = 0; n_abort_seen = 0;
    cycle(w(C_SOF, $urandom()));
    for (int i = 0; i < MAX_WORDS - 2; i++) cycle(w(C_DATA, $urandom()));
    cycle(w(C_EOF, $urandom()));
    check("full_valids", 32'(n_valid_seen), 32'(MAX_WORDS));
    check("full_no_abort", 32'(n_abort_seen), 32'd0);

    // lock loss mid-frame
    n_abort_seen = 0;
    cycle(w(C_SOF, 32'h55));
    cycle(w(C_DATA, 32'h56));
    cycle(w(C_DATA, 32'h57), 0);
    cycle(w(C_DATA, 32'h58));
    check("lockloss_abort", 32'(n_abort_seen), 32'd1);
    check("lockloss_link", 32'(link_up), 32'h0);
    check("lockloss_err", 32'(err_count), 32'd8);

    // randomized traffic
    train(LOCK_CNT);
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (!m_linked) begin
        cycle((r == 0) ? 36'(bad) : TRAIN, (r != 1), 0);
      end else if (r < 2) begin
        cycle(w(C_DATA, $urandom()), 0, 0);
      end else if (r < 4) begin
        cycle(w(C_DATA, $urandom()), 1, 1);
      end else begin
        c = $urandom_range(0, 19);
        if (c < 2) cycle(w(4'($urandom()), $urandom()));
        else if (c < 5) cycle(w(C_IDLE, $urandom()));
        else if (c < 8) cycle(w(C_SOF, $urandom()));
        else if (c < 17) cycle(w(C_DATA, $urandom()));
        else cycle(w(C_EOF, $urandom()));
      end
    end

    // reset mid-frame: no abort pulse, error count cleared
    train(LOCK_CNT);
    cycle(w(C_SOF, 32'h77));
    cycle(w(C_DATA, 32'h78), 1, 0, 1);
    check("reset_no_abort", 32'(frame_abort), 32'h0);
    check("reset_clears_err", 32'(err_count), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
